nn_result_streamer: RTL and testbench

- Read-side companion to the parallel-output inference network: consumes the network's SIZE-element signed output vector and returns results over a single-lane valid/ready stream.
- Waits a fixed pipeline latency after each inference start, snapshots the vector, then emits one beat per class score.
- Ends each frame with a final beat carrying the argmax class index.
- Sits between the network output and the host/DMA-side stream interface.

---
 rtl/nn_result_streamer.sv | 147 ++++++++++++++
 tb/tb_nn_result_streamer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_result_streamer.sv
// Result streamer: snapshots the network output vector after a fixed
// latency and emits one beat per score, then an argmax class beat.
module nn_result_streamer #(
  parameter int WIDTH   = 8,
  parameter int NFRAC   = 0,
  parameter int SIZE    = 5,
  parameter int LATENCY = 2,
  parameter int IDX_W   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] input_data [0:SIZE-1],
  output logic signed [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    dropped
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (SIZE < 2 || LATENCY < 1 || (1 << IDX_W) <= SIZE ||
      NFRAC < 0 || NFRAC > WIDTH) begin : g_param_chk
    $error("nn_result_streamer: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    CLASS
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        amax_q, amax_d;
  logic [IDX_W-1:0]        amax_c;
  logic signed [WIDTH-1:0] best;
  logic signed [WIDTH-1:0] buf_q [0:SIZE-1];
  logic signed [WIDTH-1:0] buf_d [0:SIZE-1];
  logic                    drop_q, drop_d;
  logic                    fire;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    amax_c = '0;
    best   = input_data[0];
    for (int i = 1; i < SIZE; i++) begin
      if (input_data[i] > best) begin
        best   = input_data[i];
        amax_c = IDX_W'(i);
      end
    end
  end

  assign out_valid = (state_q == SEND) || (state_q == CLASS);
  assign out_last  = (state_q == CLASS);
  assign busy      = (state_q != IDLE);
  assign dropped   = drop_q;
  assign fire      = out_valid && out_ready;

  always_comb begin
    out_data  = '0;
    out_index = '0;
    unique case (state_q)
      SEND: begin
        out_data  = buf_q[idx_q];
        out_index = idx_q;
      end
      CLASS: begin
        out_data  = WIDTH'(amax_q);
        out_index = IDX_W'(SIZE);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    amax_d  = amax_q;
    buf_d   = buf_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (start) drop_d = 1'b1;
        if (cnt_q == '0) begin
          buf_d   = input_data;
          amax_d  = amax_c;
          idx_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SEND: begin
        if (start) drop_d = 1'b1;
        if (fire) begin
          if (idx_q == IDX_W'(SIZE - 1)) state_d = CLASS;
          else idx_d = idx_q + 1'b1;
        end
      end
      CLASS: begin
        // A start on the closing handshake chains straight into the next frame.
        if (fire && start) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end else if (fire) begin
          state_d = IDLE;
        end else if (start) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      amax_q  <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < SIZE; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      amax_q  <= amax_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_nn_result_streamer.sv
// Directed bench for nn_result_streamer (SIZE=5, LATENCY=2).
// Each task drives one scenario and checks its own results.
module tb_nn_result_streamer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic signed [7:0] input_data [0:4];
  logic signed [7:0] out_data;
  logic [2:0] out_index;
  logic out_valid, out_last, busy, dropped;

  int tests = 0;
  int fails = 0;

  logic signed [7:0] rd [0:7];
  logic [2:0] ri [0:7];
  logic rl [0:7];
  int rn, hold_cnt, hold_bad;

  always #5 clk = ~clk;

  nn_result_streamer #(
    .WIDTH(8), .NFRAC(0), .SIZE(5), .LATENCY(2), .IDX_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .input_data(input_data),
    .out_data(out_data),
    .out_index(out_index),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .dropped(dropped)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic signed [7:0] a, b, c, d, e);
    input_data[0] = a;
    input_data[1] = b;
    input_data[2] = c;
    input_data[3] = d;
    input_data[4] = e;
  endtask

  // Counts cycles from the start cycle to first out_valid, presenting
  // the real vector only in the capture cycle (start + 2).
  task automatic wait_first(input logic signed [7:0] a, b, c, d, e,
                            input int lat0, output int lat,
                            output int bdrop);
    lat = lat0;
    bdrop = 0;
    while (!out_valid && lat < 20) begin
      if (lat == 2) set_vec(a, b, c, d, e);
      else set_vec(8'sd99, 8'sd99, 8'sd99, 8'sd99, 8'sd99);
      if (!busy) bdrop++;
      step;
      lat++;
    end
    set_vec(-8'sd99, -8'sd99, -8'sd99, -8'sd99, -8'sd99);
  endtask

  task automatic launch(input logic signed [7:0] a, b, c, d, e,
                        output int lat, output int bdrop);
    set_vec(8'sd99, 8'sd99, 8'sd99, 8'sd99, 8'sd99);
    start = 1'b1;
    step;
    start = 1'b0;
    wait_first(a, b, c, d, e, 1, lat, bdrop);
  endtask

  // mode 0: plain, 1: start pulse at score beat 2, 2: start on class handshake
  task automatic collect(input int mode, input int stall_at,
                         input int stalls);
    int cyc;
    int st;
    bit pulsed;
    logic signed [7:0] hd;
    cyc = 0;
    st = 0;
    pulsed = 1'b0;
    hd = '0;
    rn = 0;
    hold_cnt = 0;
    hold_bad = 0;
    while (rn < 6 && cyc < 40) begin
      out_ready = !(out_valid && int'(out_index) == stall_at &&
                    st < stalls);
      if (!out_ready) st++;
      if (out_valid && int'(out_index) == stall_at) begin
        if (hold_cnt == 0) hd = out_data;
        else if (out_data !== hd) hold_bad++;
        hold_cnt++;
      end
      start = (mode == 1 && !pulsed && out_valid && out_index == 3'd2) ||
              (mode == 2 && out_valid && out_last && out_ready);
      if (mode == 1 && start) pulsed = 1'b1;
      if (out_valid && out_ready) begin
        rd[rn] = out_data;
        ri[rn] = out_index;
        rl[rn] = out_last;
        rn++;
      end
      step;
      start = 1'b0;
      cyc++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    set_vec(8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5);
    reset = 1'b0;
    step;
    step;
    tests++;
    if ({out_valid, busy, out_last, dropped, out_data, out_index} !== '0) begin
      fails++;
      $display("FAIL reset_hold: got v=%0b b=%0b l=%0b dr=%0b d=%0d i=%0d want all 0",
               out_valid, busy, out_last, dropped, out_data, out_index);
    end
    @(negedge clk);
    reset = 1'b1;
    step;
    step;
    tests++;
    if ({out_valid, busy, out_last, dropped} !== 4'b0) begin
      fails++;
      $display("FAIL reset_release: got v=%0b b=%0b l=%0b dr=%0b want 0",
               out_valid, busy, out_last, dropped);
    end
  endtask

  task automatic test_basic;
    int lat, bd;
    logic signed [7:0] ed [0:5];
    ed = '{8'sd3, -8'sd7, 8'sd12, 8'sd12, 8'sd0, 8'sd2};
    launch(8'sd3, -8'sd7, 8'sd12, 8'sd12, 8'sd0, lat, bd);
    tests++;
    if (lat !== 3 || bd !== 0) begin
      fails++;
      $display("FAIL basic_latency: got lat=%0d busy_low=%0d want 3 0", lat, bd);
    end
    collect(0, -1, 0);
    tests++;
    if (rn !== 6) begin
      fails++;
      $display("FAIL basic_count: got %0d want 6", rn);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rd[i] !== ed[i] || int'(ri[i]) !== i || rl[i] !== (i == 5)) begin
        fails++;
        $display("FAIL basic_beat%0d: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b",
                 i, rd[i], ri[i], rl[i], ed[i], i, (i == 5));
      end
    end
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: got v=%0b b=%0b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_signed;
    int lat, bd;
    launch(-8'sd1, -8'sd2, -8'sd128, -8'sd5, -8'sd3, lat, bd);
    collect(0, -1, 0);
    tests++;
    if (rn !== 6 || rd[5] !== 8'sd0 || rd[2] !== -8'sd128) begin
      fails++;
      $display("FAIL signed_neg: got n=%0d cls=%0d s2=%0d want 6 0 -128",
               rn, rd[5], rd[2]);
    end
    launch(-8'sd128, -8'sd128, -8'sd128, -8'sd128, 8'sd127, lat, bd);
    collect(0, -1, 0);
    tests++;
    if (rn !== 6 || rd[5] !== 8'sd4 || rd[4] !== 8'sd127) begin
      fails++;
      $display("FAIL signed_ext: got n=%0d cls=%0d s4=%0d want 6 4 127",
               rn, rd[5], rd[4]);
    end
  endtask

  task automatic test_stall;
    int lat, bd;
    logic signed [7:0] ed [0:5];
    ed = '{8'sd3, -8'sd7, 8'sd12, 8'sd12, 8'sd0, 8'sd2};
    launch(8'sd3, -8'sd7, 8'sd12, 8'sd12, 8'sd0, lat, bd);
    collect(0, 1, 3);
    tests++;
    if (hold_cnt !== 4 || hold_bad !== 0) begin
      fails++;
      $display("FAIL stall_hold: got cycles=%0d changes=%0d want 4 0",
               hold_cnt, hold_bad);
    end
    tests++;
    if (rn !== 6) begin
      fails++;
      $display("FAIL stall_count: got %0d want 6", rn);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rd[i] !== ed[i] || int'(ri[i]) !== i) begin
        fails++;
        $display("FAIL stall_beat%0d: got d=%0d i=%0d want d=%0d i=%0d",
                 i, rd[i], ri[i], ed[i], i);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bd;
    launch(8'sd3, -8'sd7, 8'sd12, 8'sd12, 8'sd0, lat, bd);
    collect(2, -1, 0);
    tests++;
    if (rn !== 6 || rd[5] !== 8'sd2 || rl[5] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: got n=%0d cls=%0d l=%0b want 6 2 1",
               rn, rd[5], rl[5]);
    end
    wait_first(-8'sd128, -8'sd128, -8'sd128, -8'sd128, 8'sd127, 1, lat, bd);
    tests++;
    if (lat !== 3 || bd !== 0 || dropped !== 1'b0) begin
      fails++;
      $display("FAIL b2b_chain: got lat=%0d busy_low=%0d dr=%0b want 3 0 0",
               lat, bd, dropped);
    end
    collect(0, -1, 0);
    tests++;
    if (rn !== 6 || rd[0] !== -8'sd128 || rd[5] !== 8'sd4) begin
      fails++;
      $display("FAIL b2b_second: got n=%0d s0=%0d cls=%0d want 6 -128 4",
               rn, rd[0], rd[5]);
    end
  endtask

  task automatic test_drop;
    int lat, bd;
    launch(8'sd3, -8'sd7, 8'sd12, 8'sd12, 8'sd0, lat, bd);
    collect(1, -1, 0);
    tests++;
    if (rn !== 6 || rd[2] !== 8'sd12 || rd[5] !== 8'sd2 || dropped !== 1'b1) begin
      fails++;
      $display("FAIL drop_frame: got n=%0d s2=%0d cls=%0d dr=%0b want 6 12 2 1",
               rn, rd[2], rd[5], dropped);
    end
    step;
    tests++;
    if (busy !== 1'b0 || dropped !== 1'b1) begin
      fails++;
      $display("FAIL drop_idle: got b=%0b dr=%0b want 0 1", busy, dropped);
    end
    launch(-8'sd1, -8'sd2, -8'sd128, -8'sd5, -8'sd3, lat, bd);
    collect(0, -1, 0);
    tests++;
    if (rn !== 6 || rd[5] !== 8'sd0 || dropped !== 1'b1) begin
      fails++;
      $display("FAIL drop_next: got n=%0d cls=%0d dr=%0b want 6 0 1",
               rn, rd[5], dropped);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bd, vcnt;
    logic signed [7:0] ed [0:5];
    ed = '{-8'sd1, -8'sd2, -8'sd128, -8'sd5, -8'sd3, 8'sd0};
    launch(8'sd3, -8'sd7, 8'sd12, 8'sd12, 8'sd0, lat, bd);
    out_ready = 1'b1;
    step;
    step;
    step;
    tests++;
    if (out_valid !== 1'b1 || out_index !== 3'd3) begin
      fails++;
      $display("FAIL rmid_pre: got v=%0b i=%0d want 1 3", out_valid, out_index);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({out_valid, busy, out_last, dropped} !== 4'b0) begin
      fails++;
      $display("FAIL rmid_async: got v=%0b b=%0b l=%0b dr=%0b want 0",
               out_valid, busy, out_last, dropped);
    end
    @(negedge clk);
    reset = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      if (out_valid || busy) vcnt++;
    end
    tests++;
    if (vcnt !== 0) begin
      fails++;
      $display("FAIL rmid_quiet: got %0d active cycles want 0", vcnt);
    end
    launch(-8'sd1, -8'sd2, -8'sd128, -8'sd5, -8'sd3, lat, bd);
    collect(0, -1, 0);
    tests++;
    if (rn !== 6 || lat !== 3) begin
      fails++;
      $display("FAIL rmid_count: got n=%0d lat=%0d want 6 3", rn, lat);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rd[i] !== ed[i] || int'(ri[i]) !== i) begin
        fails++;
        $display("FAIL rmid_beat%0d: got d=%0d i=%0d want d=%0d i=%0d",
                 i, rd[i], ri[i], ed[i], i);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_stall;
    test_back_to_back;
    test_drop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
